// File: rtl/intra4_pred_calc.sv
`default_nettype none
//==============================================================================
// Module   : intra4_pred_calc
// Brief    : 4x4 intra prediction compute stage. Holds top/left reference
//            arrays and emits 16 angular or planar pixels in raster order
//            through a 2-stage pipeline with valid/ready backpressure.
//            Optional macro INTRA4_ADDR_CHECK_EN builds the addr_err check.
// Revision : 1.0 - initial release
//==============================================================================
module intra4_pred_calc #(
    parameter int BIT_DEPTH = 8,
    parameter int REF_LEN   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ref_we,
    input  logic                 ref_side,
    input  logic [3:0]           ref_addr,
    input  logic [BIT_DEPTH-1:0] ref_data,
    input  logic                 start,
    input  logic                 angle_or_planar,
    input  logic [15:0]          tol1_bus,
    input  logic [15:0]          tol2_bus,
    input  logic [127:0]         addr1_bus,
    input  logic [127:0]         addr2_bus,
    input  logic [79:0]          frac_bus,
    output logic                 busy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_DEPTH-1:0] out_pix,
    output logic [1:0]           out_x,
    output logic [1:0]           out_y,
    output logic                 out_last,
    output logic                 done,
    output logic                 addr_err
);
    // Products and sums share one width: max angular sum is 32*255+16.
    localparam int         c_ARITH_W = BIT_DEPTH + 5;
    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_RUN     = 2'd1;
    localparam logic [1:0] c_DRAIN   = 2'd2;

    logic [1:0]           r_state;
    logic [3:0]           r_cnt;
    logic                 r_busy;
    logic [15:0]          r_tol1;
    logic [15:0]          r_tol2;
    logic [63:0]          r_addr1;
    logic [63:0]          r_addr2;
    logic [79:0]          r_frac;
    logic                 r_ang;
    logic [BIT_DEPTH-1:0] r_top  [REF_LEN];
    logic [BIT_DEPTH-1:0] r_left [REF_LEN];

    logic                 r_s1_valid;
    logic                 r_s1_ang;
    logic                 r_s1_last;
    logic [1:0]           r_s1_x;
    logic [1:0]           r_s1_y;
    logic [c_ARITH_W-1:0] r_s1_t [4];

    logic                 r_out_valid;
    logic [BIT_DEPTH-1:0] r_out_pix;
    logic [1:0]           r_out_x;
    logic [1:0]           r_out_y;
    logic                 r_out_last;

    // Only the low address nibble indexes the arrays, so only it is latched.
    logic [63:0] w_nib1;
    logic [63:0] w_nib2;
    for (genvar gi = 0; gi < 16; gi++) begin : g_nib
        assign w_nib1[4*gi +: 4] = addr1_bus[8*gi +: 4];
        assign w_nib2[4*gi +: 4] = addr2_bus[8*gi +: 4];
    end

    logic                 w_stall;
    logic                 w_done;
    logic [1:0]           w_x;
    logic [1:0]           w_y;
    logic [3:0]           w_a1;
    logic [3:0]           w_a2;
    logic [6:0]           w_fidx;
    logic [4:0]           w_f;
    logic [BIT_DEPTH-1:0] w_sa;
    logic [BIT_DEPTH-1:0] w_sb;
    logic [c_ARITH_W-1:0] w_t [4];
    logic [c_ARITH_W-1:0] w_rnd;
    logic [c_ARITH_W-1:0] w_sum;
    logic [BIT_DEPTH-1:0] w_pix;

    assign w_stall = r_out_valid && !out_ready;
    assign w_done  = (r_state == c_DRAIN) && r_out_valid && out_ready && r_out_last;

    assign w_x    = r_cnt[1:0];
    assign w_y    = r_cnt[3:2];
    assign w_a1   = r_addr1[{r_cnt, 2'b00} +: 4];
    assign w_a2   = r_addr2[{r_cnt, 2'b00} +: 4];
    assign w_fidx = {3'b000, r_cnt} * 7'd5;
    assign w_f    = r_frac[w_fidx +: 5];
    assign w_sa   = r_tol1[r_cnt] ? r_top[w_a1] : r_left[w_a1];
    assign w_sb   = r_tol2[r_cnt] ? r_top[w_a2] : r_left[w_a2];

    always_comb begin
        w_t[0] = '0;
        w_t[1] = '0;
        w_t[2] = '0;
        w_t[3] = '0;
        if (r_ang) begin
            w_t[0] = c_ARITH_W'(6'd32 - {1'b0, w_f}) * c_ARITH_W'(w_sa);
            w_t[1] = c_ARITH_W'(w_f) * c_ARITH_W'(w_sb);
        end else begin
            w_t[0] = c_ARITH_W'(2'd3 - w_x) * c_ARITH_W'(w_sb);
            w_t[1] = c_ARITH_W'({1'b0, w_x} + 3'd1) * c_ARITH_W'(r_top[4]);
            w_t[2] = c_ARITH_W'(2'd3 - w_y) * c_ARITH_W'(w_sa);
            w_t[3] = c_ARITH_W'({1'b0, w_y} + 3'd1) * c_ARITH_W'(r_left[4]);
        end
    end

    assign w_rnd = r_s1_ang ? c_ARITH_W'(16) : c_ARITH_W'(4);
    assign w_sum = r_s1_t[0] + r_s1_t[1] + r_s1_t[2] + r_s1_t[3] + w_rnd;
    assign w_pix = r_s1_ang ? BIT_DEPTH'(w_sum >> 5) : BIT_DEPTH'(w_sum >> 3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_tol1  <= '0;
            r_tol2  <= '0;
            r_addr1 <= '0;
            r_addr2 <= '0;
            r_frac  <= '0;
            r_ang   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_tol1  <= tol1_bus;
                        r_tol2  <= tol2_bus;
                        r_addr1 <= w_nib1;
                        r_addr2 <= w_nib2;
                        r_frac  <= frac_bus;
                        r_ang   <= angle_or_planar;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= c_RUN;
                    end
                end
                c_RUN: begin
                    if (!w_stall) begin
                        if (r_cnt == 4'd15) begin
                            r_state <= c_DRAIN;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                end
                c_DRAIN: begin
                    if (w_done) begin
                        r_busy  <= 1'b0;
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_ang    <= 1'b0;
            r_s1_last   <= 1'b0;
            r_s1_x      <= '0;
            r_s1_y      <= '0;
            for (int i = 0; i < 4; i++) begin
                r_s1_t[i] <= '0;
            end
            r_out_valid <= 1'b0;
            r_out_pix   <= '0;
            r_out_x     <= '0;
            r_out_y     <= '0;
            r_out_last  <= 1'b0;
        end else if (!w_stall) begin
            r_s1_valid  <= (r_state == c_RUN);
            r_s1_ang    <= r_ang;
            r_s1_last   <= (r_cnt == 4'd15);
            r_s1_x      <= w_x;
            r_s1_y      <= w_y;
            for (int i = 0; i < 4; i++) begin
                r_s1_t[i] <= w_t[i];
            end
            r_out_valid <= r_s1_valid;
            r_out_pix   <= w_pix;
            r_out_x     <= r_s1_x;
            r_out_y     <= r_s1_y;
            r_out_last  <= r_s1_valid && r_s1_last;
        end
    end

    // Reference arrays are frozen while a block is in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REF_LEN; i++) begin
                r_top[i]  <= '0;
                r_left[i] <= '0;
            end
        end else if ((r_state == c_IDLE) && ref_we) begin
            if (ref_side) begin
                r_top[ref_addr] <= ref_data;
            end else begin
                r_left[ref_addr] <= ref_data;
            end
        end
    end

`ifdef INTRA4_ADDR_CHECK_EN
    logic [31:0] w_hi_bad;
    logic        r_addr_err;
    for (genvar gi = 0; gi < 16; gi++) begin : g_addr_chk
        assign w_hi_bad[gi]      = |addr1_bus[8*gi+4 +: 4];
        assign w_hi_bad[16 + gi] = |addr2_bus[8*gi+4 +: 4];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr_err <= 1'b0;
        end else if ((r_state == c_IDLE) && start) begin
            r_addr_err <= |w_hi_bad;
        end
    end

    assign addr_err = r_addr_err;
`else
    logic [31:0] w_unused_hi;
    for (genvar gi = 0; gi < 16; gi++) begin : g_addr_hi
        assign w_unused_hi[gi]      = |addr1_bus[8*gi+4 +: 4];
        assign w_unused_hi[16 + gi] = |addr2_bus[8*gi+4 +: 4];
    end

    assign addr_err = 1'b0;
`endif

    assign busy      = r_busy;
    assign out_valid = r_out_valid;
    assign out_pix   = r_out_pix;
    assign out_x     = r_out_x;
    assign out_y     = r_out_y;
    assign out_last  = r_out_last;
    assign done      = w_done;

endmodule
`default_nettype wire

// File: tb/tb_intra4_pred_calc.sv
`default_nettype none
//==============================================================================
// Module   : tb_intra4_pred_calc
// Brief    : Self-checking bench for intra4_pred_calc against a pixel model
//            computed directly from the angular/planar formulas.
// Revision : 1.0 - initial release
//==============================================================================
module tb_intra4_pred_calc;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ref_we = 1'b0;
    logic         ref_side = 1'b0;
    logic [3:0]   ref_addr = '0;
    logic [7:0]   ref_data = '0;
    logic         start = 1'b0;
    logic         angle_or_planar = 1'b0;
    logic [15:0]  tol1_bus = '0;
    logic [15:0]  tol2_bus = '0;
    logic [127:0] addr1_bus = '0;
    logic [127:0] addr2_bus = '0;
    logic [79:0]  frac_bus = '0;
    logic         busy;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [7:0]   out_pix;
    logic [1:0]   out_x;
    logic [1:0]   out_y;
    logic         out_last;
    logic         done;
    logic         addr_err;

    always #5 clk = ~clk;

    intra4_pred_calc #(.BIT_DEPTH(8), .REF_LEN(16)) dut (
        .clk(clk), .rst(rst), .ref_we(ref_we), .ref_side(ref_side),
        .ref_addr(ref_addr), .ref_data(ref_data), .start(start),
        .angle_or_planar(angle_or_planar), .tol1_bus(tol1_bus), .tol2_bus(tol2_bus),
        .addr1_bus(addr1_bus), .addr2_bus(addr2_bus), .frac_bus(frac_bus),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .out_pix(out_pix),
        .out_x(out_x), .out_y(out_y), .out_last(out_last), .done(done), .addr_err(addr_err)
    );

    int n_vec = 0;
    int n_err = 0;
    int m_top[16];
    int m_left[16];
    bit s_tol1[16];
    bit s_tol2[16];
    int s_a1[16];
    int s_a2[16];
    int s_fr[16];
    bit s_ang;

    function automatic int model_pix(int p);
        int x, y, a, b, f;
        x = p % 4;
        y = p / 4;
        a = s_tol1[p] ? m_top[s_a1[p] % 16] : m_left[s_a1[p] % 16];
        b = s_tol2[p] ? m_top[s_a2[p] % 16] : m_left[s_a2[p] % 16];
        f = s_fr[p];
        if (s_ang) return ((32 - f) * a + f * b + 16) / 32;
        return ((3 - x) * b + (x + 1) * m_top[4] + (3 - y) * a + (y + 1) * m_left[4] + 4) / 8;
    endfunction

    function automatic bit model_addr_err();
        bit e;
        e = 0;
        for (int p = 0; p < 16; p++) begin
            if ((s_a1[p] / 16) != 0 || (s_a2[p] / 16) != 0) e = 1;
        end
        return e;
    endfunction

    task automatic drive_buses();
        logic [7:0] a1, a2;
        logic [4:0] f;
        for (int p = 0; p < 16; p++) begin
            a1 = 8'(s_a1[p]);
            a2 = 8'(s_a2[p]);
            f  = 5'(s_fr[p]);
            tol1_bus[p] = s_tol1[p];
            tol2_bus[p] = s_tol2[p];
            addr1_bus[8*p +: 8] = a1;
            addr2_bus[8*p +: 8] = a2;
            frac_bus[5*p +: 5]  = f;
        end
        angle_or_planar = s_ang;
    endtask

    task automatic write_ref(input bit side, input int addr, input int data);
        ref_we = 1'b1;
        ref_side = side;
        ref_addr = 4'(addr);
        ref_data = 8'(data);
        @(negedge clk);
        ref_we = 1'b0;
        if (side) m_top[addr] = data;
        else m_left[addr] = data;
    endtask

    task automatic load_refs(input bit rnd, input int val);
        for (int i = 0; i < 16; i++) begin
            write_ref(1'b1, i, rnd ? int'($urandom_range(0, 255)) : val);
            write_ref(1'b0, i, rnd ? int'($urandom_range(0, 255)) : val);
        end
    endtask

    task automatic rand_stim(input bit ang, input bit hi_ok);
        for (int p = 0; p < 16; p++) begin
            s_tol1[p] = 1'($urandom_range(0, 1));
            s_tol2[p] = 1'($urandom_range(0, 1));
            s_a1[p] = hi_ok ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 15));
            s_a2[p] = hi_ok ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 15));
            s_fr[p] = int'($urandom_range(0, 31));
        end
        s_ang = ang;
    endtask

    // Upstream planar addressing: A = top[x], B = left[y].
    task automatic planar_stim();
        for (int p = 0; p < 16; p++) begin
            s_tol1[p] = 1'b1;
            s_a1[p] = p % 4;
            s_tol2[p] = 1'b0;
            s_a2[p] = p / 4;
            s_fr[p] = int'($urandom_range(0, 31));
        end
        s_ang = 1'b0;
    endtask

    task automatic uniform_stim(input int a1, input int a2, input int f);
        for (int p = 0; p < 16; p++) begin
            s_tol1[p] = 1'b1;
            s_tol2[p] = 1'b1;
            s_a1[p] = a1;
            s_a2[p] = a2;
            s_fr[p] = f;
        end
        s_ang = 1'b1;
    endtask

    // Called at a negedge; returns at a negedge with the DUT idle.
    // mode 0: ready high, 1: random ready, 2: ready low for stall_len cycles at pixel stall_pix.
    task automatic run_block(input int mode, input int stall_pix, input int stall_len, input bit poke);
        int got, cyc, dones, stall_left, first_v, exp_v;
        bit stall_done, held, exp_err;
        logic [7:0] hp;
        logic [1:0] hx, hy;
        got = 0; cyc = 0; dones = 0; stall_left = 0; first_v = -1;
        stall_done = 0; held = 0; hp = '0; hx = '0; hy = '0;
        exp_err = model_addr_err();
        drive_buses();
        start = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL busy_after_start: got %b expected 1", busy);
        end
`ifdef INTRA4_ADDR_CHECK_EN
        n_vec++;
        if (addr_err !== exp_err) begin
            n_err++;
            $display("FAIL addr_err_latch: got %b expected %b", addr_err, exp_err);
        end
`else
        n_vec++;
        if (addr_err !== 1'b0) begin
            n_err++;
            $display("FAIL addr_err_tied: got %b expected 0", addr_err);
        end
`endif
        while (got < 16 && cyc < 400) begin
            if (mode == 2) begin
                if (stall_left > 0) begin
                    stall_left--;
                    out_ready = 1'b0;
                end else if (!stall_done && out_valid && got == stall_pix) begin
                    stall_done = 1;
                    stall_left = stall_len - 1;
                    out_ready = 1'b0;
                end else begin
                    out_ready = 1'b1;
                end
            end else if (mode == 1) begin
                out_ready = 1'($urandom_range(0, 1));
            end else begin
                out_ready = 1'b1;
            end
            if (poke && cyc == 5) begin
                ref_we = 1'b1;
                ref_side = 1'b1;
                ref_addr = 4'd4;
                ref_data = 8'(~m_top[4]);
                start = 1'b1;
                angle_or_planar = ~s_ang;
                tol1_bus = 16'($urandom);
                tol2_bus = 16'($urandom);
                addr1_bus = {$urandom, $urandom, $urandom, $urandom};
                addr2_bus = {$urandom, $urandom, $urandom, $urandom};
                frac_bus = {16'($urandom), $urandom, $urandom};
            end else if (poke && cyc == 6) begin
                ref_we = 1'b0;
                start = 1'b0;
                drive_buses();
            end
            #1;
            if (first_v < 0 && out_valid) first_v = cyc;
            if (held) begin
                n_vec++;
                if (out_valid !== 1'b1 || out_pix !== hp || out_x !== hx || out_y !== hy) begin
                    n_err++;
                    $display("FAIL stall_hold: got v=%b pix=%0d x=%0d y=%0d expected v=1 pix=%0d x=%0d y=%0d",
                             out_valid, out_pix, out_x, out_y, hp, hx, hy);
                end
            end
            if (out_valid && out_ready) begin
                exp_v = model_pix(got);
                n_vec++;
                if (out_pix !== 8'(exp_v)) begin
                    n_err++;
                    $display("FAIL pixel[%0d]: got %0d expected %0d", got, out_pix, exp_v);
                end
                n_vec++;
                if ({out_y, out_x} !== 4'(got)) begin
                    n_err++;
                    $display("FAIL xy[%0d]: got x=%0d y=%0d expected x=%0d y=%0d", got, out_x, out_y, got % 4, got / 4);
                end
                n_vec++;
                if (out_last !== (got == 15)) begin
                    n_err++;
                    $display("FAIL last[%0d]: got %b expected %b", got, out_last, got == 15);
                end
                n_vec++;
                if (done !== (got == 15)) begin
                    n_err++;
                    $display("FAIL done_at[%0d]: got %b expected %b", got, done, got == 15);
                end
                if (done) dones++;
                got++;
            end else if (done) begin
                n_vec++;
                n_err++;
                dones++;
                $display("FAIL done_spurious: got 1 expected 0 at cycle %0d", cyc);
            end
            held = out_valid && !out_ready;
            hp = out_pix;
            hx = out_x;
            hy = out_y;
            if (got < 16) begin
                @(negedge clk);
                cyc++;
            end
        end
        n_vec++;
        if (got != 16) begin
            n_err++;
            $display("FAIL block_timeout: got %0d pixels expected 16", got);
        end
        n_vec++;
        if (first_v != 3) begin
            n_err++;
            $display("FAIL first_valid_latency: got %0d expected 3", first_v);
        end
        n_vec++;
        if (dones != 1) begin
            n_err++;
            $display("FAIL done_count: got %0d expected 1", dones);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        n_vec++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL idle_after_block: got busy=%b valid=%b done=%b expected 0 0 0", busy, out_valid, done);
        end
`ifdef INTRA4_ADDR_CHECK_EN
        n_vec++;
        if (addr_err !== exp_err) begin
            n_err++;
            $display("FAIL addr_err_sticky: got %b expected %b", addr_err, exp_err);
        end
`endif
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_vec++;
        if ({busy, out_valid, out_pix, out_x, out_y, out_last, done, addr_err} !== 16'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {busy, out_valid, out_pix, out_x, out_y, out_last, done, addr_err});
        end
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            m_top[i] = 0;
            m_left[i] = 0;
        end
        rand_stim(1'b1, 1'b0);
        run_block(0, 0, 0, 1'b0);
    endtask

    task automatic test_planar_flat();
        load_refs(1'b0, 100);
        planar_stim();
        run_block(0, 0, 0, 1'b0);
    endtask

    task automatic test_planar_gradient();
        load_refs(1'b0, 0);
        write_ref(1'b1, 4, 64);
        planar_stim();
        run_block(0, 0, 0, 1'b0);
    endtask

    task automatic test_angular();
        write_ref(1'b1, 2, 0);
        write_ref(1'b1, 3, 64);
        uniform_stim(2, 3, 16);
        run_block(0, 0, 0, 1'b0);
        write_ref(1'b1, 2, 77);
        uniform_stim(2, 3, 0);
        run_block(0, 0, 0, 1'b0);
        write_ref(1'b1, 2, 255);
        write_ref(1'b1, 3, 0);
        uniform_stim(2, 3, 31);
        run_block(0, 0, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        load_refs(1'b1, 0);
        planar_stim();
        run_block(2, 3, 5, 1'b0);
        rand_stim(1'b1, 1'b0);
        run_block(2, 9, 3, 1'b0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            load_refs(1'b1, 0);
            rand_stim(1'($urandom_range(0, 1)), 1'b1);
            run_block(1, 0, 0, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 3; k++) begin
            rand_stim(1'($urandom_range(0, 1)), 1'b0);
            run_block(0, 0, 0, 1'b0);
        end
    endtask

    task automatic test_ignored_inputs();
        load_refs(1'b1, 0);
        planar_stim();
        run_block(0, 0, 0, 1'b1);
        rand_stim(1'b1, 1'b0);
        run_block(1, 0, 0, 1'b1);
        planar_stim();
        run_block(0, 0, 0, 1'b0);
    endtask

    task automatic test_reset_midblock();
        bit found;
        load_refs(1'b1, 0);
        rand_stim(1'b0, 1'b0);
        drive_buses();
        start = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int c = 0; c < 60 && !found; c++) begin
            if (out_valid && out_x == 2'd3 && out_y == 2'd1) found = 1;
            else @(negedge clk);
        end
        n_vec++;
        if (!found) begin
            n_err++;
            $display("FAIL reset_mid_reach: got no pixel 7 expected pixel 7 pending");
        end
        out_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if ({busy, out_valid, out_pix, out_x, out_y, out_last, done, addr_err} !== 16'd0) begin
            n_err++;
            $display("FAIL reset_mid_outputs: got %h expected 0",
                     {busy, out_valid, out_pix, out_x, out_y, out_last, done, addr_err});
        end
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            m_top[i] = 0;
            m_left[i] = 0;
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            n_vec++;
            if (done !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL reset_mid_quiet: got done=%b valid=%b busy=%b expected 0 0 0", done, out_valid, busy);
            end
        end
        @(negedge clk);
        planar_stim();
        run_block(0, 0, 0, 1'b0);
        load_refs(1'b1, 0);
        rand_stim(1'b1, 1'b0);
        run_block(0, 0, 0, 1'b0);
    endtask

    task automatic test_addr_check();
        load_refs(1'b1, 0);
        rand_stim(1'b1, 1'b0);
        s_a1[5] = 8'h13;
        s_tol1[5] = 1'b1;
        run_block(0, 0, 0, 1'b0);
        rand_stim(1'b1, 1'b0);
        run_block(0, 0, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_planar_flat();
        test_planar_gradient();
        test_angular();
        test_backpressure();
        test_random();
        test_back_to_back();
        test_ignored_inputs();
        test_reset_midblock();
        test_addr_check();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
